multi_phase_seq: RTL

MULTI_PHASE_SEQ -- requirements
Module: multi_phase_seq

---
 rtl/multi_phase_seq_if.sv | 47 ++++
 rtl/multi_phase_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multi_phase_seq_if.sv
// -----------------------------------------------------------------------------
// multi_phase_seq_if
//   Bundles the instruction-field inputs and phase/control outputs of the
//   multi-phase instruction sequencer.
//
//   master : datapath side, drives the IR fields, ALU flag and memory handshake.
//   slave  : sequencer side (multi_phase_seq), drives the phase strobes and
//            control outputs.
//
//   Signals
//     Op[5:0]        opcode field from IR, valid from the first P1 cycle
//     IRFunc[5:0]    R-type function field from IR, valid with Op
//     OV             ALU overflow flag, meaningful during P2
//     MemReady       memory handshake, high = access complete this cycle
//     P0..P4         one-hot phase strobes: fetch/decode/execute/memory/writeback
//     P              halt/illegal-opcode indicator
//     Func[5:0]      ALU function code for the current instruction
//     WrEn           register-file write enable
//     Done           single-cycle retire pulse
//     InstrCnt[15:0] retired-instruction counter
// -----------------------------------------------------------------------------
interface multi_phase_seq_if;
  logic [5:0]  Op;
  logic [5:0]  IRFunc;
  logic        OV;
  logic        MemReady;
  logic        P0;
  logic        P1;
  logic        P2;
  logic        P3;
  logic        P4;
  logic        P;
  logic [5:0]  Func;
  logic        WrEn;
  logic        Done;
  logic [15:0] InstrCnt;

  modport master (
    output Op, IRFunc, OV, MemReady,
    input  P0, P1, P2, P3, P4, P, Func, WrEn, Done, InstrCnt
  );

  modport slave (
    input  Op, IRFunc, OV, MemReady,
    output P0, P1, P2, P3, P4, P, Func, WrEn, Done, InstrCnt
  );
endinterface

// File: rtl/multi_phase_seq.sv
// -----------------------------------------------------------------------------
// multi_phase_seq
//   Five-phase instruction sequencer (fetch, decode, execute, memory,
//   writeback) with a sticky halt state for illegal opcodes.
//
//   Ports
//     clk   sole clock, rising edge
//     clr   synchronous active-low reset
//     bus   multi_phase_seq_if.slave: IR fields, OV and MemReady in;
//           phase strobes P0..P4/P, Func, WrEn, Done, InstrCnt out
//
//   Phase sequences
//     R-type, addi, lw : S0-S1-S2-S3-S4
//     sw               : S0-S1-S2-S3
//     beq, j           : S0-S1-S2
//     anything else    : S0-S1-SH (held until reset)
//
//   Build option
//     MEM_STALL_EN  when defined, S0 (instruction fetch) and the S3 memory
//                   phase of lw/sw hold until MemReady=1. When undefined,
//                   MemReady is ignored and every phase lasts one cycle.
// -----------------------------------------------------------------------------
module multi_phase_seq (
  input logic              clk,
  input logic              clr,
  multi_phase_seq_if.slave bus
);

  // One-hot encoding so the phase strobes come straight from the state flops.
  typedef enum logic [5:0] {
    S0 = 6'b000001,
    S1 = 6'b000010,
    S2 = 6'b000100,
    S3 = 6'b001000,
    S4 = 6'b010000,
    SH = 6'b100000
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  state_t      state;
  logic [5:0]  opReg;
  logic [5:0]  fnReg;
  logic        ovReg;
  logic [15:0] instrCnt;

  logic        memOk;
  logic        done;
  logic        wrEn;
  logic [5:0]  func;

`ifdef MEM_STALL_EN
  assign memOk = bus.MemReady;
`else
  logic unusedMemReady;
  assign unusedMemReady = bus.MemReady;
  assign memOk          = 1'b1;
`endif

  function automatic logic [5:0] decodeFunc(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] f;
    case (op)
      OP_RTYPE:              f = fn;
      OP_LW, OP_SW, OP_ADDI: f = FN_ADD;
      OP_BEQ:                f = FN_SUB;
      default:               f = '0;
    endcase
    return f;
  endfunction

  // The IR fields only become valid in S1 and are captured at the end of that
  // cycle, so S1 decodes the live fields and later phases use the captured copy.
  always_comb begin
    func = '0;
    done = 1'b0;
    wrEn = 1'b0;
    case (state)
      S1: func = decodeFunc(bus.Op, bus.IRFunc);
      S2: begin
        func = decodeFunc(opReg, fnReg);
        done = (opReg == OP_BEQ) || (opReg == OP_J);
      end
      S3: begin
        func = decodeFunc(opReg, fnReg);
        done = (opReg == OP_SW) && memOk;
      end
      S4: begin
        // Only R-type, addi and lw reach S4; lw ignores overflow.
        func = decodeFunc(opReg, fnReg);
        done = 1'b1;
        wrEn = (opReg == OP_LW) || !ovReg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= S0;
      opReg    <= '0;
      fnReg    <= '0;
      ovReg    <= 1'b0;
      instrCnt <= '0;
    end else begin
      instrCnt <= instrCnt + {15'd0, done};
      case (state)
        S0: begin
          if (memOk) state <= S1;
        end
        S1: begin
          opReg <= bus.Op;
          fnReg <= bus.IRFunc;
          case (bus.Op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: state <= S2;
            default:                                       state <= SH;
          endcase
        end
        S2: begin
          if ((opReg == OP_BEQ) || (opReg == OP_J)) begin
            state <= S0;
            ovReg <= 1'b0;
          end else begin
            state <= S3;
            ovReg <= bus.OV;
          end
        end
        S3: begin
          if (opReg == OP_SW) begin
            if (memOk) begin
              state <= S0;
              ovReg <= 1'b0;
            end
          end else if (opReg == OP_LW) begin
            if (memOk) state <= S4;
          end else begin
            state <= S4;
          end
        end
        S4: begin
          state <= S0;
          ovReg <= 1'b0;
        end
        SH:      state <= SH;
        default: state <= S0;
      endcase
    end
  end

  assign bus.P0       = state[0];
  assign bus.P1       = state[1];
  assign bus.P2       = state[2];
  assign bus.P3       = state[3];
  assign bus.P4       = state[4];
  assign bus.P        = state[5];
  assign bus.Func     = func;
  assign bus.WrEn     = wrEn;
  assign bus.Done     = done;
  assign bus.InstrCnt = instrCnt;

endmodule
